// File: rtl/peripheral_io.sv
// Memory-mapped peripheral block behind the ALU: reload timer with IRQ, LEDs,
// synchronised switches, 7-segment register and a byte-wide UART interface.
module peripheral_io #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  input  logic [LED_W-1:0] switch,
  output logic [11:0]      digi,
  output logic             irqout,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_start,
  input  logic             uart_tx_busy,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid
);

  localparam int unsigned DW      = 32;
  localparam int unsigned DIGI_W  = 12;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned TCON_W  = 3;

  localparam logic [31:0] A_TH   = BASE_ADDR + 32'h00;
  localparam logic [31:0] A_TL   = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_TCON = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_LED  = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_SW   = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_DIGI = BASE_ADDR + 32'h14;
  localparam logic [31:0] A_TXD  = BASE_ADDR + 32'h18;
  localparam logic [31:0] A_RXD  = BASE_ADDR + 32'h1C;
  localparam logic [31:0] A_UCON = BASE_ADDR + 32'h20;

  logic [DW-1:0]     th_q, th_d;
  logic [DW-1:0]     tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [BYTE_W-1:0] txd_q, txd_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] rxd_q, rxd_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic [LED_W-1:0]  sw_sync_q [SYNC_STAGES];

  logic tx_busy;
  logic tmr_ovf;
  logic irq_set;
  logic rx_rd;

  assign tx_busy = uart_tx_busy | tx_start_q;
  assign tmr_ovf = tcon_q[0] & (tl_q == '1);
  assign irq_set = tmr_ovf & tcon_q[1];
  assign rx_rd   = rd & (addr == A_RXD);

  assign led           = led_q;
  assign digi          = digi_q;
  assign irqout        = tcon_q[1] & tcon_q[2];
  assign uart_tx_data  = txd_q;
  assign uart_tx_start = tx_start_q;

  // Next-state: timer advance first, then bus writes override where they collide.
  always_comb begin
    th_d       = th_q;
    tl_d       = tl_q;
    tcon_d     = tcon_q;
    led_d      = led_q;
    digi_d     = digi_q;
    txd_d      = txd_q;
    tx_start_d = 1'b0;
    rxd_d      = rxd_q;
    rx_full_d  = rx_full_q;
    rx_ovr_d   = rx_ovr_q;

    if (tcon_q[0]) begin
      tl_d = tmr_ovf ? th_q : tl_q + 32'd1;
    end
    if (irq_set) begin
      tcon_d[2] = 1'b1;
    end

    if (wr) begin
      case (addr)
        A_TH:    th_d   = wdata;
        A_TL:    tl_d   = wdata;
        A_TCON:  tcon_d = {wdata[2] | irq_set, wdata[1:0]};
        A_LED:   led_d  = wdata[LED_W-1:0];
        A_DIGI:  digi_d = wdata[DIGI_W-1:0];
        A_TXD: begin
          if (!tx_busy) begin
            txd_d      = wdata[BYTE_W-1:0];
            tx_start_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A read of RXD acknowledges; a byte arriving in the same cycle re-arms rx_full.
    if (rx_rd) begin
      rx_full_d = 1'b0;
      rx_ovr_d  = 1'b0;
    end
    if (uart_rx_valid) begin
      rxd_d     = uart_rx_data;
      rx_full_d = 1'b1;
      rx_ovr_d  = rx_rd ? 1'b0 : (rx_ovr_q | rx_full_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q       <= '0;
      tl_q       <= '0;
      tcon_q     <= '0;
      led_q      <= '0;
      digi_q     <= '0;
      txd_q      <= '0;
      tx_start_q <= 1'b0;
      rxd_q      <= '0;
      rx_full_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      led_q      <= led_d;
      digi_q     <= digi_d;
      txd_q      <= txd_d;
      tx_start_q <= tx_start_d;
      rxd_q      <= rxd_d;
      rx_full_q  <= rx_full_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // Switch pins are asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= switch;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        A_TH:    rdata = th_q;
        A_TL:    rdata = tl_q;
        A_TCON:  rdata = DW'(tcon_q);
        A_LED:   rdata = DW'(led_q);
        A_SW:    rdata = DW'(sw_sync_q[SYNC_STAGES-1]);
        A_DIGI:  rdata = DW'(digi_q);
        A_TXD:   rdata = DW'(txd_q);
        A_RXD:   rdata = DW'(rxd_q);
        A_UCON:  rdata = DW'({rx_ovr_q, rx_full_q, tx_busy});
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_io.sv
// Self-checking bench for peripheral_io: decode table plus timer, reset,
// switch synchroniser and UART sequences, read data checked through a scoreboard.
module tb_peripheral_io;

  localparam logic [31:0] B      = 32'h4000_0000;
  localparam logic [31:0] A_TH   = B + 32'h00;
  localparam logic [31:0] A_TL   = B + 32'h04;
  localparam logic [31:0] A_TCON = B + 32'h08;
  localparam logic [31:0] A_LED  = B + 32'h0C;
  localparam logic [31:0] A_SW   = B + 32'h10;
  localparam logic [31:0] A_DIGI = B + 32'h14;
  localparam logic [31:0] A_TXD  = B + 32'h18;
  localparam logic [31:0] A_RXD  = B + 32'h1C;
  localparam logic [31:0] A_UCON = B + 32'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  led, switch;
  logic [11:0] digi;
  logic        irqout;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start, uart_tx_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  peripheral_io dut (
    .clk           (clk),
    .reset         (reset),
    .rd            (rd),
    .wr            (wr),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .led           (led),
    .switch        (switch),
    .digi          (digi),
    .irqout        (irqout),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle, started just after a falling edge; rdata is sampled before the rising edge.
  task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic chk_en, input logic [31:0] exp, input string name);
    sb_t e;
    wr = w; rd = r; addr = a; wdata = d;
    if (chk_en) sb_q.push_back('{name, exp});
    #1;
    if (chk_en) begin
      e = sb_q.pop_front();
      chk(e.name, rdata, e.exp);
    end
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d, 1'b0, 32'h0, "");
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus(1'b0, 1'b1, a, 32'h0, 1'b1, exp, name);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    switch = '0; uart_tx_busy = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_digi", 32'(digi), 32'h0);
    chk("rst_irq", 32'(irqout), 32'h0);
    chk("rst_txstart", 32'(uart_tx_start), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    rd_reg(A_TL, 32'h0, "rst_tl");
    rd_reg(A_UCON, 32'h0, "rst_ucon");

    // Decode / read-write table
    vecs.push_back('{1'b1, 1'b0, A_LED,          32'h0000_00AA, 32'h0,         "wr_led"});
    vecs.push_back('{1'b0, 1'b1, A_LED,          32'h0,         32'h0000_00AA, "rd_led"});
    vecs.push_back('{1'b0, 1'b1, B + 32'h24,     32'h0,         32'h0,         "rd_unmapped"});
    vecs.push_back('{1'b0, 1'b1, B + 32'h01,     32'h0,         32'h0,         "rd_misaligned"});
    vecs.push_back('{1'b1, 1'b0, B + 32'h24,     32'hFFFF_FFFF, 32'h0,         "wr_unmapped"});
    vecs.push_back('{1'b1, 1'b0, B + 32'h0D,     32'h0000_0055, 32'h0,         "wr_misaligned"});
    vecs.push_back('{1'b1, 1'b0, 32'h5000_000C,  32'h0000_0077, 32'h0,         "wr_outside"});
    vecs.push_back('{1'b0, 1'b1, A_LED,          32'h0,         32'h0000_00AA, "rd_led_kept"});
    vecs.push_back('{1'b1, 1'b1, A_LED,          32'h0000_0033, 32'h0000_00AA, "rdwr_led_old"});
    vecs.push_back('{1'b0, 1'b1, A_LED,          32'h0,         32'h0000_0033, "rd_led_new"});
    vecs.push_back('{1'b1, 1'b0, A_TH,           32'h1234_5678, 32'h0,         "wr_th"});
    vecs.push_back('{1'b0, 1'b1, A_TH,           32'h0,         32'h1234_5678, "rd_th"});
    vecs.push_back('{1'b1, 1'b0, A_DIGI,         32'hFFFF_FFFF, 32'h0,         "wr_digi"});
    vecs.push_back('{1'b0, 1'b1, A_DIGI,         32'h0,         32'h0000_0FFF, "rd_digi"});
    vecs.push_back('{1'b1, 1'b0, A_SW,           32'h0000_00FF, 32'h0,         "wr_sw_ro"});
    vecs.push_back('{1'b0, 1'b1, A_SW,           32'h0,         32'h0,         "rd_sw"});
    vecs.push_back('{1'b1, 1'b0, A_UCON,         32'h0000_0007, 32'h0,         "wr_ucon_ro"});
    vecs.push_back('{1'b0, 1'b1, A_UCON,         32'h0,         32'h0,         "rd_ucon"});
    vecs.push_back('{1'b0, 1'b0, A_LED,          32'h0,         32'h0,         "no_rd"});
    vecs.push_back('{1'b1, 1'b0, A_TCON,         32'hFFFF_FFF8, 32'h0,         "wr_tcon_hi"});
    vecs.push_back('{1'b0, 1'b1, A_TCON,         32'h0,         32'h0,         "rd_tcon_masked"});
    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, 1'b1, vecs[i].exp, vecs[i].name);
    end
    chk("led_pin", 32'(led), 32'h33);
    chk("digi_pin", 32'(digi), 32'hFFF);

    // Timer reload and interrupt
    wr_reg(A_TH, 32'hFFFF_FFFC);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'h3);
    rd_reg(A_TL, 32'hFFFF_FFFE, "tl_start");
    chk("irq_before", 32'(irqout), 32'h0);
    rd_reg(A_TL, 32'hFFFF_FFFF, "tl_max");
    chk("irq_reload", 32'(irqout), 32'h1);
    rd_reg(A_TL, 32'hFFFF_FFFC, "tl_reload");
    wr_reg(A_TCON, 32'h3);
    chk("irq_cleared", 32'(irqout), 32'h0);
    rd_reg(A_TL, 32'hFFFF_FFFE, "tl_count");
    wr_reg(A_TCON, 32'h3);
    chk("irq_no_loss", 32'(irqout), 32'h1);
    rd_reg(A_TCON, 32'h7, "tcon_no_loss");
    wr_reg(A_TL, 32'h5);
    rd_reg(A_TL, 32'h5, "tl_wr_wins");

    // Reset mid-run while counting with irq pending
    reset = 1'b0; rd = 1'b1; addr = A_TL;
    #1;
    chk("mid_rst_irq", 32'(irqout), 32'h0);
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_digi", 32'(digi), 32'h0);
    chk("mid_rst_tl", rdata, 32'h0);
    rd = 1'b0; addr = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(); idle();
    rd_reg(A_TL, 32'h0, "tl_frozen");
    wr_reg(A_TCON, 32'h1);
    rd_reg(A_TL, 32'h0, "tl_restart0");
    rd_reg(A_TL, 32'h1, "tl_restart1");
    wr_reg(A_TCON, 32'h0);

    // Switch synchroniser latency
    switch = 8'h5A;
    rd_reg(A_SW, 32'h0, "sw_lat0");
    rd_reg(A_SW, 32'h0, "sw_lat1");
    rd_reg(A_SW, 32'h5A, "sw_seen");

    // UART transmit
    wr_reg(A_TXD, 32'h41);
    chk("tx_start_hi", 32'(uart_tx_start), 32'h1);
    chk("tx_data", 32'(uart_tx_data), 32'h41);
    wr_reg(A_TXD, 32'h42);
    chk("tx_start_lo", 32'(uart_tx_start), 32'h0);
    rd_reg(A_TXD, 32'h41, "txd_kept");
    uart_tx_busy = 1'b1;
    wr_reg(A_TXD, 32'h43);
    chk("tx_busy_nostart", 32'(uart_tx_start), 32'h0);
    rd_reg(A_TXD, 32'h41, "txd_busy_kept");
    rd_reg(A_UCON, 32'h1, "ucon_busy");
    uart_tx_busy = 1'b0;

    // UART receive with overrun and same-cycle read/arrival
    uart_rx_valid = 1'b1; uart_rx_data = 8'h10;
    idle();
    uart_rx_data = 8'h20;
    idle();
    uart_rx_valid = 1'b0;
    rd_reg(A_UCON, 32'h6, "ucon_overrun");
    rd_reg(A_RXD, 32'h20, "rxd_last");
    rd_reg(A_UCON, 32'h0, "ucon_cleared");
    uart_rx_valid = 1'b1; uart_rx_data = 8'h30;
    rd_reg(A_RXD, 32'h20, "rxd_old_on_hit");
    uart_rx_valid = 1'b0;
    rd_reg(A_UCON, 32'h2, "ucon_full_only");
    rd_reg(A_RXD, 32'h30, "rxd_new");
    rd_reg(A_UCON, 32'h0, "ucon_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
